// File: rtl/sobel_window_ctrl.sv
// -----------------------------------------------------------------------------
// sobel_window_ctrl
//
// Sequencer for a 3x3 Sobel window datapath built from two cascaded line-buffer
// shift FIFOs (IMG_WIDTH cells each) feeding a bank of window registers.
// Pixels arrive in raster order over a valid/ready handshake. Every accepted
// pixel produces exactly one shift of the FIFOs and window registers. The
// controller tracks the raster position and flags the shifts that leave a
// complete, non-wrapping 3x3 window in the window registers.
//
// Ports
//   CLK           system clock, rising edge
//   RSTn          synchronous active-low reset
//   Start         one-cycle pulse, starts a frame when idle
//   In_Valid      source presents a pixel this cycle
//   In_Ready      controller accepts pixels this cycle (state only)
//   Enable        shift enable for line buffers and window registers
//   Window_Valid  window registers hold a complete 3x3 window
//   Win_Row       centre row of the current window
//   Win_Col       centre column of the current window
//   Busy          frame in progress
//   Done          one-cycle pulse after the last pixel of a frame
//
// State  | Meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for Start, no pixels accepted
// RUN    | accepting pixels, counters advance on each accept
// DONE   | single cycle after the last pixel, Done pulse, then IDLE
// -----------------------------------------------------------------------------
module sobel_window_ctrl #(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  localparam int CW = $clog2(IMG_WIDTH),
  localparam int RW = $clog2(IMG_HEIGHT)
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          Start,
  input  logic          In_Valid,
  output logic          In_Ready,
  output logic          Enable,
  output logic          Window_Valid,
  output logic [RW-1:0] Win_Row,
  output logic [CW-1:0] Win_Col,
  output logic          Busy,
  output logic          Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic          fullWindow;
  logic          lastPixel;

  // In_Ready is a register, so the shift enable is one AND gate away from
  // In_Valid and there is no loop back into the source's valid logic.
  assign accept = In_Valid & In_Ready;
  assign Enable = accept;

  // Columns 0 and 1 would mix pixels from the end of the previous line into
  // the window, and rows 0-1 only fill the line buffers.
  assign fullWindow = (row >= RW'(2)) && (col >= CW'(2));
  assign lastPixel  = (row == LAST_ROW) && (col == LAST_COL);

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      In_Ready     <= 1'b0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Window_Valid <= 1'b0;
      Win_Row      <= '0;
      Win_Col      <= '0;
    end else begin
      Window_Valid <= 1'b0;
      Done         <= 1'b0;

      // Window qualification for the pixel shifted in on this edge; the
      // centre of the window lags the newest pixel by one row and one column.
      if (accept && fullWindow) begin
        Window_Valid <= 1'b1;
        Win_Row      <= row - RW'(1);
        Win_Col      <= col - CW'(1);
      end

      case (state)
        IDLE: begin
          if (Start) begin
            state    <= RUN;
            col      <= '0;
            row      <= '0;
            In_Ready <= 1'b1;
            Busy     <= 1'b1;
          end
        end

        RUN: begin
          if (accept) begin
            if (lastPixel) begin
              state    <= DONE;
              In_Ready <= 1'b0;
              Busy     <= 1'b0;
              Done     <= 1'b1;
            end else if (col == LAST_COL) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
        end

        DONE: begin
          // Start is deliberately not looked at here; a new frame needs a
          // Start while IDLE.
          state <= IDLE;
        end

        default: begin
          state    <= IDLE;
          In_Ready <= 1'b0;
          Busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
module tb_sobel_window_ctrl;

  localparam int W    = 32;
  localparam int H    = 32;
  localparam int NPIX = W * H;
  localparam int NWIN = (W - 2) * (H - 2);

  logic       CLK;
  logic       RSTn;
  logic       Start;
  logic       In_Valid;
  logic       In_Ready;
  logic       Enable;
  logic       Window_Valid;
  logic [4:0] Win_Row;
  logic [4:0] Win_Col;
  logic       Busy;
  logic       Done;

  logic       sStart;
  logic       sValid;
  logic       sReady;
  logic       sEnable;
  logic       sWv;
  logic [1:0] sRow;
  logic [1:0] sCol;
  logic       sBusy;
  logic       sDone;

  int vectors;
  int miscompares;

  sobel_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .CLK(CLK), .RSTn(RSTn), .Start(Start), .In_Valid(In_Valid),
    .In_Ready(In_Ready), .Enable(Enable), .Window_Valid(Window_Valid),
    .Win_Row(Win_Row), .Win_Col(Win_Col), .Busy(Busy), .Done(Done)
  );

  sobel_window_ctrl #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dutSmall (
    .CLK(CLK), .RSTn(RSTn), .Start(sStart), .In_Valid(sValid),
    .In_Ready(sReady), .Enable(sEnable), .Window_Valid(sWv),
    .Win_Row(sRow), .Win_Col(sCol), .Busy(sBusy), .Done(sDone)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Runs one full frame on the default-size DUT starting from IDLE. Expected
  // window flags and coordinates come from the pixel index of each accept.
  task automatic run_frame(input bit stall, input bit pokeStart, input string tag);
    int  p, cyc, enCnt, wvCnt, r, c, firstIdx;
    bit  expWv;
    int  expR, expC;
    p = 0; cyc = 0; enCnt = 0; wvCnt = 0; firstIdx = -1;
    expWv = 1'b0; expR = 0; expC = 0;
    Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    while (p < NPIX && cyc < 20000) begin
      In_Valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      Start    = pokeStart && (p == 100 || p == 700);
      @(negedge CLK);
      vectors++;
      if (In_Ready !== 1'b1) begin
        miscompares++;
        $display("FAIL %s ready p=%0d: got %b want 1", tag, p, In_Ready);
      end
      vectors++;
      if (Enable !== In_Valid) begin
        miscompares++;
        $display("FAIL %s enable p=%0d: got %b want %b", tag, p, Enable, In_Valid);
      end
      vectors++;
      if (Busy !== 1'b1 || Done !== 1'b0) begin
        miscompares++;
        $display("FAIL %s busy/done p=%0d: got %b/%b want 1/0", tag, p, Busy, Done);
      end
      vectors++;
      if (Window_Valid !== expWv) begin
        miscompares++;
        $display("FAIL %s window_valid p=%0d: got %b want %b", tag, p, Window_Valid, expWv);
      end
      if (expWv) begin
        vectors++;
        if (Win_Row !== 5'(expR) || Win_Col !== 5'(expC)) begin
          miscompares++;
          $display("FAIL %s coord p=%0d: got (%0d,%0d) want (%0d,%0d)",
                   tag, p, Win_Row, Win_Col, expR, expC);
        end
      end
      if (Window_Valid === 1'b1) begin
        wvCnt++;
        if (firstIdx < 0) firstIdx = p - 1;
        vectors++;
        if (Win_Col === 5'd0 || Win_Col === 5'(W - 1)) begin
          miscompares++;
          $display("FAIL %s wrap_col p=%0d: got col %0d want 1..%0d", tag, p, Win_Col, W - 2);
        end
      end
      if (Enable === 1'b1) enCnt++;
      if (In_Valid) begin
        r = p / W;
        c = p % W;
        expWv = (r >= 2) && (c >= 2);
        expR = r - 1;
        expC = c - 1;
        p++;
      end else begin
        expWv = 1'b0;
      end
      @(posedge CLK); #1;
      cyc++;
    end
    vectors++;
    if (cyc >= 20000) begin
      miscompares++;
      $display("FAIL %s timeout: accepted %0d want %0d", tag, p, NPIX);
    end
    // DONE cycle: source keeps offering data and Start is poked.
    In_Valid = 1'b1;
    Start    = pokeStart;
    @(negedge CLK);
    vectors++;
    if (Done !== 1'b1 || Busy !== 1'b0 || In_Ready !== 1'b0 || Enable !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done_cycle: got done=%b busy=%b ready=%b en=%b want 1/0/0/0",
               tag, Done, Busy, In_Ready, Enable);
    end
    vectors++;
    if (Window_Valid !== 1'b1 || Win_Row !== 5'd30 || Win_Col !== 5'd30) begin
      miscompares++;
      $display("FAIL %s last_window: got v=%b (%0d,%0d) want v=1 (30,30)",
               tag, Window_Valid, Win_Row, Win_Col);
    end
    if (Window_Valid === 1'b1) wvCnt++;
    if (Enable === 1'b1) enCnt++;
    @(posedge CLK); #1;
    Start = 1'b0;
    vectors++;
    if (enCnt !== NPIX) begin
      miscompares++;
      $display("FAIL %s enable_count: got %0d want %0d", tag, enCnt, NPIX);
    end
    vectors++;
    if (wvCnt !== NWIN) begin
      miscompares++;
      $display("FAIL %s window_count: got %0d want %0d", tag, wvCnt, NWIN);
    end
    vectors++;
    if (firstIdx !== 2 * W + 2) begin
      miscompares++;
      $display("FAIL %s first_window_index: got %0d want %0d", tag, firstIdx, 2 * W + 2);
    end
    // Back in IDLE: nothing accepted, no second frame, coordinates held.
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      vectors++;
      if (In_Ready !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || Enable !== 1'b0 ||
          Window_Valid !== 1'b0) begin
        miscompares++;
        $display("FAIL %s idle_after: got ready=%b busy=%b done=%b en=%b wv=%b want all 0",
                 tag, In_Ready, Busy, Done, Enable, Window_Valid);
      end
      vectors++;
      if (Win_Row !== 5'd30 || Win_Col !== 5'd30) begin
        miscompares++;
        $display("FAIL %s coord_hold: got (%0d,%0d) want (30,30)", tag, Win_Row, Win_Col);
      end
      @(posedge CLK); #1;
    end
    In_Valid = 1'b0;
  endtask

  task automatic test_reset();
    RSTn = 1'b0; Start = 1'b1; In_Valid = 1'b1; sStart = 1'b1; sValid = 1'b1;
    @(posedge CLK); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      vectors++;
      if ({In_Ready, Enable, Window_Valid, Win_Row, Win_Col, Busy, Done} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs: got ready=%b en=%b wv=%b row=%0d col=%0d busy=%b done=%b want all 0",
                 In_Ready, Enable, Window_Valid, Win_Row, Win_Col, Busy, Done);
      end
      vectors++;
      if ({sReady, sEnable, sWv, sRow, sCol, sBusy, sDone} !== '0) begin
        miscompares++;
        $display("FAIL reset_small: got ready=%b en=%b wv=%b busy=%b done=%b want all 0",
                 sReady, sEnable, sWv, sBusy, sDone);
      end
      @(posedge CLK); #1;
    end
    RSTn = 1'b1; Start = 1'b0; In_Valid = 1'b0; sStart = 1'b0; sValid = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    vectors++;
    if (In_Ready !== 1'b0 || Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got ready=%b busy=%b want 0/0", In_Ready, Busy);
    end
    @(posedge CLK); #1;
    Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    @(negedge CLK);
    vectors++;
    if (In_Ready !== 1'b1 || Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_start: got ready=%b busy=%b want 1/1", In_Ready, Busy);
    end
    RSTn = 1'b0;
    @(posedge CLK); #1;
    RSTn = 1'b1;
  endtask

  task automatic test_full_frame();
    run_frame(1'b0, 1'b0, "full_frame");
  endtask

  task automatic test_stalls();
    run_frame(1'b1, 1'b0, "stalls");
  endtask

  task automatic test_ignored_start();
    run_frame(1'b0, 1'b1, "ignored_start");
  endtask

  task automatic test_mid_frame_reset();
    int cnt, cyc;
    cnt = 0; cyc = 0;
    Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    In_Valid = 1'b1;
    while (cnt < 500 && cyc < 2000) begin
      @(negedge CLK);
      if (Enable === 1'b1) cnt++;
      vectors++;
      if (Done !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_early_done: got %b want 0", Done);
      end
      @(posedge CLK); #1;
      cyc++;
    end
    vectors++;
    if (cnt !== 500) begin
      miscompares++;
      $display("FAIL midreset_accepts: got %0d want 500", cnt);
    end
    RSTn = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    vectors++;
    if ({In_Ready, Enable, Window_Valid, Win_Row, Win_Col, Busy, Done} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got ready=%b en=%b wv=%b row=%0d col=%0d busy=%b done=%b want all 0",
               In_Ready, Enable, Window_Valid, Win_Row, Win_Col, Busy, Done);
    end
    @(posedge CLK); #1;
    RSTn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      vectors++;
      if (Done !== 1'b0 || Busy !== 1'b0 || Enable !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_quiet: got done=%b busy=%b en=%b want 0/0/0", Done, Busy, Enable);
      end
      @(posedge CLK); #1;
    end
    In_Valid = 1'b0;
    run_frame(1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_small_config();
    int expR[4];
    int expC[4];
    int gotR[$];
    int gotC[$];
    int acc, cyc;
    bit seenDone;
    expR = '{1, 1, 2, 2};
    expC = '{1, 2, 1, 2};
    acc = 0; cyc = 0; seenDone = 1'b0;
    sStart = 1'b1;
    @(posedge CLK); #1;
    sStart = 1'b0;
    sValid = 1'b1;
    while (!seenDone && cyc < 40) begin
      @(negedge CLK);
      if (sWv === 1'b1) begin
        gotR.push_back(int'(sRow));
        gotC.push_back(int'(sCol));
      end
      if (sDone === 1'b1) seenDone = 1'b1;
      else if (sEnable === 1'b1) acc++;
      @(posedge CLK); #1;
      cyc++;
    end
    sValid = 1'b0;
    vectors++;
    if (!seenDone) begin
      miscompares++;
      $display("FAIL small_done: no Done within 40 cycles, want Done after 16 accepts");
    end
    vectors++;
    if (acc !== 16) begin
      miscompares++;
      $display("FAIL small_accepts: got %0d want 16", acc);
    end
    vectors++;
    if (gotR.size() !== 4) begin
      miscompares++;
      $display("FAIL small_window_count: got %0d want 4", gotR.size());
    end
    for (int i = 0; i < 4 && i < gotR.size(); i++) begin
      vectors++;
      if (gotR[i] !== expR[i] || gotC[i] !== expC[i]) begin
        miscompares++;
        $display("FAIL small_window%0d: got (%0d,%0d) want (%0d,%0d)",
                 i, gotR[i], gotC[i], expR[i], expC[i]);
      end
    end
    @(negedge CLK);
    vectors++;
    if (sBusy !== 1'b0 || sReady !== 1'b0 || sDone !== 1'b0) begin
      miscompares++;
      $display("FAIL small_idle: got busy=%b ready=%b done=%b want 0/0/0", sBusy, sReady, sDone);
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    RSTn = 1'b0; Start = 1'b0; In_Valid = 1'b0; sStart = 1'b0; sValid = 1'b0;
    test_reset();
    test_full_frame();
    test_stalls();
    test_mid_frame_reset();
    test_ignored_start();
    test_small_config();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sobel_window_ctrl.md
Name: sobel_window_ctrl

Overview:
- Sequencer for the 3x3 Sobel window datapath: two cascaded 32-cell line-buffer shift FIFOs plus window registers.
- Accepts a raster pixel stream through a valid/ready handshake and drives the shared shift enable for the line buffers.
- Tracks row/column position and flags which shifts produce a complete, non-wrapping 3x3 window.
- Brackets one frame per Start pulse, with Busy/Done status for the host.

Parameters:
IMG_WIDTH, 32, pixels per line; must equal line-buffer depth (32-cell FIFO)
IMG_HEIGHT, 32, lines per frame; minimum 3
CW, $clog2(IMG_WIDTH), column counter width (derived, not overridden)
RW, $clog2(IMG_HEIGHT), row counter width (derived, not overridden)

Ports:
CLK  input  1  system clock, rising edge
RSTn  input  1  synchronous active-low reset
Start  input  1  one-cycle pulse; begins a frame when idle
In_Valid  input  1  source presents a pixel on the datapath DataIn this cycle
In_Ready  output  1  controller can accept a pixel this cycle
Enable  output  1  shift enable to both line-buffer FIFOs and window registers
Window_Valid  output  1  window registers hold a complete valid 3x3 window
Win_Row  output  RW  centre row of the current window
Win_Col  output  CW  centre column of the current window
Busy  output  1  frame in progress
Done  output  1  one-cycle pulse after the last pixel of a frame

Behaviour:
- Reset: when RSTn is low at a rising edge, all state clears on that edge.
  - Outputs after reset: In_Ready=0, Enable=0, Window_Valid=0, Win_Row=0, Win_Col=0, Busy=0, Done=0.
  - Counters clear to 0 and the FSM returns to IDLE.
  - Reset mid-frame abandons the frame. No Done pulse; line-buffer contents are don't-care.
- FSM states: IDLE, RUN, DONE.
  - IDLE: In_Ready=0, Busy=0. Start=1 -> RUN, with col=0 and row=0.
  - RUN: In_Ready=1, Busy=1. Accepting the pixel at row=IMG_HEIGHT-1, col=IMG_WIDTH-1 -> DONE.
  - DONE: lasts exactly one cycle with Done=1, In_Ready=0, Busy=0; then -> IDLE.
  - Start is ignored outside IDLE.
- Handshake:
  - accept = In_Valid & In_Ready.
  - Enable = accept, combinational, in the same cycle as the pixel on DataIn. The FIFOs shift exactly once per accepted pixel.
  - In_Valid low in RUN: Enable=0, counters hold, FIFO contents hold (stall).
- Counters advance on accept only.
  - col increments; at IMG_WIDTH-1 it wraps to 0 and row increments.
  - row does not wrap inside a frame; the frame ends instead.
- Window qualification, registered with 1-cycle latency from the accepting edge:
  - Window_Valid=1 in the cycle after an accept where row>=2 and col>=2.
  - In that cycle, Win_Row=row-1 and Win_Col=col-1 of the accepted pixel.
  - Otherwise Window_Valid=0, and Win_Row/Win_Col hold their last values.
  - col<2 windows straddle a line wrap and are suppressed.
  - Rows 0-1 are fill-only.
- Latency and counts:
  - First Window_Valid follows accepted pixel index 2*IMG_WIDTH+2 (0-based); 66 at defaults.
  - Valid windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2); 900 at defaults.
  - Window_Valid for the final pixel coincides with the Done cycle.
- Simultaneous events:
  - RSTn low overrides Start and In_Valid.
  - Start asserted during the DONE cycle is ignored. A new frame requires Start in IDLE.
- Implementation constraints: no combinational path from In_Valid to In_Ready; In_Ready depends on state only.

Test Plan:
- Reset: hold RSTn=0 with Start=1 and In_Valid=1 for 3 cycles -> all outputs 0, Enable=0, state IDLE; Start after release -> In_Ready=1 next cycle.
- Full frame, defaults, In_Valid held 1: 1024 Enable pulses; 900 Window_Valid cycles.
  - First window at Win_Row=1, Win_Col=1, one cycle after pixel 66.
  - Last window at Win_Row=30, Win_Col=30, coinciding with the Done pulse.
  - Busy=0 afterwards.
- Row boundary: observe the accepts at col=0 and col=1 of rows 2..31 -> Window_Valid=0 on the following cycles; Win_Col never reads 0 or 31 while Window_Valid=1.
- Stalls: random In_Valid (50% duty) -> Enable == In_Valid during RUN; coordinate sequence identical to the no-stall run; still 900 windows.
- Mid-frame reset: RSTn=0 after 500 accepts -> no Done pulse; a new Start gives a full, correct 900-window frame.
- Ignored Start: Start pulses during RUN and during the DONE cycle -> no counter restart; no second frame without a Start in IDLE.
- Small config: IMG_WIDTH=4, IMG_HEIGHT=4 -> 4 windows at (1,1), (1,2), (2,1), (2,2); Done after 16 accepts.
